// File: rtl/spi_reg_hub_pkg.sv
// ----------------------------------------------------------------------------
// spi_reg_hub_pkg
// Shared definitions for the SPI register hub: command space codes, the
// session state encoding, fixed word widths and a shifter alignment helper.
//
// Optional build macro used by the hub: SPI_REG_HUB_SHADOW_EN
// (see rtl/spi_reg_hub.sv).
// ----------------------------------------------------------------------------
package spi_reg_hub_pkg;

    localparam logic [7:0] HUB_VERSION = 8'h02;

    localparam int CMD_W     = 8;   // command byte
    localparam int STATUS_W  = 16;  // status prefix of a buffer read
    localparam int TBL_PRE_W = 16;  // table start-address preload word
    localparam int ID_W      = 32;  // ID/capability word
    localparam int SH_W      = 32;  // shifter width, covers the widest word

    // cmd[6:5]
    typedef enum logic [1:0] {
        SP_CFG = 2'b00,
        SP_BUF = 2'b01,
        SP_TBL = 2'b10,
        SP_ID  = 2'b11
    } space_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CMD    = 3'd1,
        ST_CFG    = 3'd2,
        ST_BUF    = 3'd3,
        ST_TBL_A  = 3'd4,
        ST_TBL    = 3'd5,
        ST_ID     = 3'd6,
        ST_IGNORE = 3'd7
    } state_e;

    // The transmit shifter always sends from its top bit, so a w-bit word is
    // placed in the upper w bits.
    function automatic logic [SH_W-1:0] msb_align(input logic [SH_W-1:0] v,
                                                   input int unsigned     w);
        return v << (SH_W - w);
    endfunction

endpackage

// File: rtl/spi_hub_sync.sv
// ----------------------------------------------------------------------------
// spi_hub_sync
// Brings the asynchronous SPI pins into the clk domain with 2-FF
// synchronisers and derives single-cycle edge pulses.
//
// Ports:
//   clk, rst_n      system clock, asynchronous active-low reset
//   ncs_spi         chip select pin (active low)
//   sck_spi         SPI clock pin
//   mosi_spi        SPI data-in pin
//   sck_rise        1-clk pulse on synced SCK rising edge
//   sck_fall        1-clk pulse on synced SCK falling edge
//   session_start   1-clk pulse on synced ncs falling edge
//   session_end     1-clk pulse on synced ncs rising edge
//   mosi_s          synced MOSI, aligned with the synced SCK
//   spi_busy        synced ncs is low
// ----------------------------------------------------------------------------
module spi_hub_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic ncs_spi,
    input  logic sck_spi,
    input  logic mosi_spi,
    output logic sck_rise,
    output logic sck_fall,
    output logic session_start,
    output logic session_end,
    output logic mosi_s,
    output logic spi_busy
);

    // [0] first flop, [1] synced value, [2] previous synced value
    logic [2:0] r_sck;
    logic [2:0] r_ncs;
    logic [1:0] r_mosi;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sck  <= '0;
            r_ncs  <= '1;   // deselected, so no session edge comes out of reset
            r_mosi <= '0;
        end else begin
            r_sck  <= {r_sck[1:0], sck_spi};
            r_ncs  <= {r_ncs[1:0], ncs_spi};
            r_mosi <= {r_mosi[0], mosi_spi};
        end
    end

    assign sck_rise      =  r_sck[1] & ~r_sck[2];
    assign sck_fall      = ~r_sck[1] &  r_sck[2];
    assign session_start = ~r_ncs[1] &  r_ncs[2];
    assign session_end   =  r_ncs[1] & ~r_ncs[2];
    // Same depth as the SCK path, so the value seen with sck_rise is the bit
    // the master set up before that edge.
    assign mosi_s        =  r_mosi[1];
    assign spi_busy      = ~r_ncs[1];

endmodule

// File: rtl/spi_reg_hub.sv
// ----------------------------------------------------------------------------
// spi_reg_hub
// SPI mode-0 slave hub. A command byte {write, space[1:0], index[4:0]}
// selects one of:
//   00 CFG : NUM_CFG config registers, readback + write, auto-increment burst
//   01 BUF : 16-bit status prefix then sequential buffer RAM words
//   10 TBL : 16-bit start address, then writes into table port <index>
//   11 ID  : {DEV_ID, HUB_VERSION, NUM_CFG, NUM_TBL}
// MISO returns DEV_ID while the command byte shifts in. Data is MSB first,
// MOSI sampled on SCK rise, MISO advanced on SCK fall. clk >= 8x f_sck.
//
// Ports:
//   clk, rst_n        system clock, asynchronous active-low reset
//   ncs_spi, sck_spi, mosi_spi, miso_spi   SPI pins
//   cmd_out           last latched command byte
//   cfg_out           config registers, reg k at [k*CFG_W +: CFG_W]
//   cfg_wr_stb        1-clk commit strobe per register
//   status_in         status word sent ahead of buffer data
//   mem_addr/mem_data buffer RAM read port (data 1 clk after address)
//   tbl_addr/tbl_data shared table write address/data
//   tbl_we            1-clk write enable per table
//   spi_busy          session active (synced ncs low)
//   dbg_state         current session state
//
// Build option SPI_REG_HUB_SHADOW_EN: config writes go to shadow registers
// (readback shows the shadow) and all registers written during a session
// are copied to cfg_out together, with their strobes, when ncs rises.
// Without it, each config word commits as soon as it has been received.
// ----------------------------------------------------------------------------
module spi_reg_hub
    import spi_reg_hub_pkg::*;
#(
    parameter int               NUM_CFG = 4,
    parameter int               CFG_W   = 32,
    parameter logic [CFG_W-1:0] CFG_RST = '0,
    parameter int               NUM_TBL = 2,
    parameter int               TBL_AW  = 9,
    parameter int               TBL_DW  = 8,
    parameter int               MEM_AW  = 11,
    parameter int               MEM_DW  = 16,
    parameter logic [7:0]       DEV_ID  = 8'h91
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     ncs_spi,
    input  logic                     sck_spi,
    input  logic                     mosi_spi,
    output logic                     miso_spi,
    output logic [7:0]               cmd_out,
    output logic [NUM_CFG*CFG_W-1:0] cfg_out,
    output logic [NUM_CFG-1:0]       cfg_wr_stb,
    input  logic [15:0]              status_in,
    output logic [MEM_AW-1:0]        mem_addr,
    input  logic [MEM_DW-1:0]        mem_data,
    output logic [TBL_AW-1:0]        tbl_addr,
    output logic [TBL_DW-1:0]        tbl_data,
    output logic [NUM_TBL-1:0]       tbl_we,
    output logic                     spi_busy,
    output state_e                   dbg_state
);

    localparam int         CI_W      = (NUM_CFG > 1) ? $clog2(NUM_CFG) : 1;
    localparam int         TI_W      = (NUM_TBL > 1) ? $clog2(NUM_TBL) : 1;
    localparam logic [5:0] NUM_CFG_L = 6'(NUM_CFG);
    localparam logic [5:0] NUM_TBL_L = 6'(NUM_TBL);

    // ------------------------------------------------------------------
    // Pin synchronisation
    // ------------------------------------------------------------------
    logic w_sck_rise;
    logic w_sck_fall;
    logic w_session_start;
    logic w_session_end;
    logic w_mosi_s;
    logic w_busy;

    spi_hub_sync u_sync (
        .clk           (clk),
        .rst_n         (rst_n),
        .ncs_spi       (ncs_spi),
        .sck_spi       (sck_spi),
        .mosi_spi      (mosi_spi),
        .sck_rise      (w_sck_rise),
        .sck_fall      (w_sck_fall),
        .session_start (w_session_start),
        .session_end   (w_session_end),
        .mosi_s        (w_mosi_s),
        .spi_busy      (w_busy)
    );

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_e              r_state;
    logic [SH_W-1:0]     r_tx;        // MISO shifter, sends bit SH_W-1
    logic [SH_W-1:0]     r_rx;        // MOSI shifter, fills from bit 0
    logic [5:0]          r_bit;       // bits received in the current word
    logic [5:0]          r_len;       // length of the current word
    logic [4:0]          r_idx;       // current cfg register / table port
    logic [7:0]          r_cmd;
    logic [CFG_W-1:0]    r_cfg [NUM_CFG];
    logic [NUM_CFG-1:0]  r_cfg_stb;
    logic [MEM_AW-1:0]   r_mem_addr;
    logic [TBL_AW-1:0]   r_tbl_addr;
    logic [TBL_DW-1:0]   r_tbl_data;
    logic [NUM_TBL-1:0]  r_tbl_we;
    logic                r_tbl_inc;   // advance tbl_addr after a write pulse
`ifdef SPI_REG_HUB_SHADOW_EN
    logic [CFG_W-1:0]    r_shadow [NUM_CFG];
    logic [NUM_CFG-1:0]  r_dirty;     // registers written this session
`endif

    // ------------------------------------------------------------------
    // Word assembly and decode
    // ------------------------------------------------------------------
    logic [SH_W-1:0]    w_rx_next;
    logic [5:0]         w_bit_next;
    logic               w_word_end;
    logic [7:0]         w_cmd;
    logic               w_cmd_wr;
    space_e             w_cmd_sp;
    logic [4:0]         w_cmd_idx;
    logic [CI_W-1:0]    w_cmd_csel;
    logic [CI_W-1:0]    w_cfg_sel;
    logic [CI_W-1:0]    w_cfg_nsel;
    logic               w_cfg_last;
    logic [CFG_W-1:0]   w_rd_cmd;     // readback for the commanded register
    logic [CFG_W-1:0]   w_rd_next;    // readback for the next register
    logic [NUM_TBL-1:0] w_tbl_onehot;
    logic [ID_W-1:0]    w_id_word;

    assign w_rx_next  = {r_rx[SH_W-2:0], w_mosi_s};
    assign w_bit_next = r_bit + 6'd1;
    assign w_word_end = w_sck_rise && (w_bit_next == r_len);

    // Command fields as they will be on the 8th rise
    assign w_cmd      = w_rx_next[7:0];
    assign w_cmd_wr   = w_cmd[7];
    assign w_cmd_sp   = space_e'(w_cmd[6:5]);
    assign w_cmd_idx  = w_cmd[4:0];
    assign w_cmd_csel = w_cmd_idx[CI_W-1:0];

    assign w_cfg_sel  = r_idx[CI_W-1:0];
    assign w_cfg_nsel = w_cfg_sel + CI_W'(1);
    assign w_cfg_last = ({1'b0, r_idx} + 6'd1) >= NUM_CFG_L;

    assign w_id_word  = {DEV_ID, HUB_VERSION, 8'(NUM_CFG), 8'(NUM_TBL)};

    always_comb begin
        w_tbl_onehot = '0;
        w_tbl_onehot[r_idx[TI_W-1:0]] = 1'b1;
`ifdef SPI_REG_HUB_SHADOW_EN
        w_rd_cmd  = r_shadow[w_cmd_csel];
        w_rd_next = r_shadow[w_cfg_nsel];
`else
        w_rd_cmd  = r_cfg[w_cmd_csel];
        w_rd_next = r_cfg[w_cfg_nsel];
`endif
    end

    // ------------------------------------------------------------------
    // Session state machine and datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_tx       <= '0;
            r_rx       <= '0;
            r_bit      <= '0;
            r_len      <= '0;
            r_idx      <= '0;
            r_cmd      <= '0;
            r_cfg_stb  <= '0;
            r_mem_addr <= '0;
            r_tbl_addr <= '0;
            r_tbl_data <= '0;
            r_tbl_we   <= '0;
            r_tbl_inc  <= 1'b0;
            for (int k = 0; k < NUM_CFG; k++) begin
                r_cfg[k] <= CFG_RST;
            end
`ifdef SPI_REG_HUB_SHADOW_EN
            for (int k = 0; k < NUM_CFG; k++) begin
                r_shadow[k] <= CFG_RST;
            end
            r_dirty <= '0;
`endif
        end else begin
            r_cfg_stb <= '0;
            r_tbl_we  <= '0;
            r_tbl_inc <= 1'b0;

            if (r_tbl_inc) begin
                r_tbl_addr <= r_tbl_addr + TBL_AW'(1);
            end

            if (w_session_end) begin
                // A partially shifted word is simply dropped here.
                r_state <= ST_IDLE;
                r_bit   <= '0;
                r_tx    <= '0;
`ifdef SPI_REG_HUB_SHADOW_EN
                for (int k = 0; k < NUM_CFG; k++) begin
                    if (r_dirty[k]) begin
                        r_cfg[k] <= r_shadow[k];
                    end
                end
                r_cfg_stb <= r_dirty;
                r_dirty   <= '0;
`endif
            end else if (w_session_start) begin
                r_state <= ST_CMD;
                r_bit   <= '0;
                r_len   <= 6'(CMD_W);
                r_rx    <= '0;
                r_tx    <= msb_align(SH_W'(DEV_ID), CMD_W);
            end else if (r_state != ST_IDLE) begin
                // A freshly loaded word (r_bit == 0) must keep its first bit
                // on MISO through the fall that follows the loading rise.
                if (w_sck_fall && (r_bit != '0)) begin
                    r_tx <= r_tx << 1;
                end

                if (w_sck_rise) begin
                    r_rx  <= w_rx_next;
                    r_bit <= w_word_end ? 6'd0 : w_bit_next;
                end

                if (w_word_end) begin
                    case (r_state)
                        ST_CMD: begin
                            r_cmd <= w_cmd;
                            r_idx <= w_cmd_idx;
                            case (w_cmd_sp)
                                SP_CFG: begin
                                    if ({1'b0, w_cmd_idx} >= NUM_CFG_L) begin
                                        r_state <= ST_IGNORE;
                                        r_tx    <= '0;
                                    end else begin
                                        r_state <= ST_CFG;
                                        r_len   <= 6'(CFG_W);
                                        r_tx    <= msb_align(SH_W'(w_rd_cmd), CFG_W);
                                    end
                                end
                                SP_BUF: begin
                                    r_state    <= ST_BUF;
                                    r_len      <= 6'(STATUS_W);
                                    r_tx       <= msb_align(SH_W'(status_in), STATUS_W);
                                    r_mem_addr <= '0;
                                end
                                SP_TBL: begin
                                    if (!w_cmd_wr || ({1'b0, w_cmd_idx} >= NUM_TBL_L)) begin
                                        r_state <= ST_IGNORE;
                                    end else begin
                                        r_state <= ST_TBL_A;
                                        r_len   <= 6'(TBL_PRE_W);
                                    end
                                    r_tx <= '0;
                                end
                                default: begin  // SP_ID
                                    r_state <= ST_ID;
                                    r_len   <= 6'(ID_W);
                                    r_tx    <= msb_align(SH_W'(w_id_word), ID_W);
                                end
                            endcase
                        end

                        ST_CFG: begin
                            if (r_cmd[7]) begin
`ifdef SPI_REG_HUB_SHADOW_EN
                                r_shadow[w_cfg_sel] <= w_rx_next[CFG_W-1:0];
                                r_dirty[w_cfg_sel]  <= 1'b1;
`else
                                r_cfg[w_cfg_sel]     <= w_rx_next[CFG_W-1:0];
                                r_cfg_stb[w_cfg_sel] <= 1'b1;
`endif
                            end
                            if (w_cfg_last) begin
                                r_state <= ST_IGNORE;
                                r_tx    <= '0;
                            end else begin
                                r_idx <= r_idx + 5'd1;
                                r_tx  <= msb_align(SH_W'(w_rd_next), CFG_W);
                            end
                        end

                        ST_BUF: begin
                            // mem_data already reflects mem_addr, which has
                            // been stable for a whole word.
                            r_len      <= 6'(MEM_DW);
                            r_tx       <= msb_align(SH_W'(mem_data), MEM_DW);
                            r_mem_addr <= r_mem_addr + MEM_AW'(1);
                        end

                        ST_TBL_A: begin
                            r_state    <= ST_TBL;
                            r_len      <= 6'(TBL_DW);
                            r_tbl_addr <= w_rx_next[TBL_AW-1:0];
                        end

                        ST_TBL: begin
                            r_tbl_data <= w_rx_next[TBL_DW-1:0];
                            r_tbl_we   <= w_tbl_onehot;
                            r_tbl_inc  <= 1'b1;
                        end

                        ST_ID: begin
                            r_state <= ST_IGNORE;
                            r_tx    <= '0;
                        end

                        default: begin
                        end
                    endcase
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    logic w_miso_en;
    assign w_miso_en = (r_state == ST_CMD) || (r_state == ST_CFG) ||
                       (r_state == ST_BUF) || (r_state == ST_ID);

    // Gated by the raw pin as well so MISO drops as soon as ncs rises.
    assign miso_spi = ~ncs_spi & w_busy & w_miso_en & r_tx[SH_W-1];

    for (genvar k = 0; k < NUM_CFG; k++) begin : g_cfg_out
        assign cfg_out[k*CFG_W +: CFG_W] = r_cfg[k];
    end

    assign cmd_out    = r_cmd;
    assign cfg_wr_stb = r_cfg_stb;
    assign mem_addr   = r_mem_addr;
    assign tbl_addr   = r_tbl_addr;
    assign tbl_data   = r_tbl_data;
    assign tbl_we     = r_tbl_we;
    assign spi_busy   = w_busy;
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_spi_reg_hub.sv
// ----------------------------------------------------------------------------
// tb_spi_reg_hub
// Directed bench for spi_reg_hub (default parameters). Drives SPI mode-0
// sessions with SCK = clk/16, models the buffer RAM as RAM[i] = i + 0x100,
// and logs config strobes and table writes from the DUT outputs.
// ----------------------------------------------------------------------------
module tb_spi_reg_hub;
    import spi_reg_hub_pkg::*;

    localparam int NUM_CFG = 4;
    localparam int CFG_W   = 32;
    localparam int NUM_TBL = 2;
    localparam int TBL_AW  = 9;
    localparam int TBL_DW  = 8;
    localparam int MEM_AW  = 11;
    localparam int MEM_DW  = 16;
    localparam int HALF    = 80;   // SCK half period, 8 clk cycles

    // ------------------------------------------------------------------
    // Clock / reset / DUT
    // ------------------------------------------------------------------
    logic                     clk      = 1'b0;
    logic                     rst_n    = 1'b0;
    logic                     ncs_spi  = 1'b1;
    logic                     sck_spi  = 1'b0;
    logic                     mosi_spi = 1'b0;
    logic                     miso_spi;
    logic [7:0]               cmd_out;
    logic [NUM_CFG*CFG_W-1:0] cfg_out;
    logic [NUM_CFG-1:0]       cfg_wr_stb;
    logic [15:0]              status_in = 16'h0;
    logic [MEM_AW-1:0]        mem_addr;
    logic [MEM_DW-1:0]        mem_data = '0;
    logic [TBL_AW-1:0]        tbl_addr;
    logic [TBL_DW-1:0]        tbl_data;
    logic [NUM_TBL-1:0]       tbl_we;
    logic                     spi_busy;
    state_e                   dbg_state;

    always #5 clk = ~clk;

    spi_reg_hub dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ncs_spi    (ncs_spi),
        .sck_spi    (sck_spi),
        .mosi_spi   (mosi_spi),
        .miso_spi   (miso_spi),
        .cmd_out    (cmd_out),
        .cfg_out    (cfg_out),
        .cfg_wr_stb (cfg_wr_stb),
        .status_in  (status_in),
        .mem_addr   (mem_addr),
        .mem_data   (mem_data),
        .tbl_addr   (tbl_addr),
        .tbl_data   (tbl_data),
        .tbl_we     (tbl_we),
        .spi_busy   (spi_busy),
        .dbg_state  (dbg_state)
    );

    // Buffer RAM model: RAM[i] = i + 0x100, one clk read latency
    always @(posedge clk) begin
        mem_data <= 16'h0100 + 16'(mem_addr);
    end

    // ------------------------------------------------------------------
    // Output monitors (cumulative high-cycle counts and a write log)
    // ------------------------------------------------------------------
    int          stb_cnt [NUM_CFG];
    int          we_cnt  [NUM_TBL];
    logic [31:0] tbl_log [$];   // {we[7:0], addr[15:0], data[7:0]}

    always @(negedge clk) begin
        for (int k = 0; k < NUM_CFG; k++) begin
            if (cfg_wr_stb[k]) stb_cnt[k]++;
        end
        for (int k = 0; k < NUM_TBL; k++) begin
            if (tbl_we[k]) we_cnt[k]++;
        end
        if (tbl_we != '0) begin
            tbl_log.push_back({8'(tbl_we), 16'(tbl_addr), 8'(tbl_data)});
        end
    end

    function automatic logic [31:0] stb_vec();
        return {8'(stb_cnt[3]), 8'(stb_cnt[2]), 8'(stb_cnt[1]), 8'(stb_cnt[0])};
    endfunction

    function automatic logic [15:0] we_vec();
        return {8'(we_cnt[1]), 8'(we_cnt[0])};
    endfunction

    // ------------------------------------------------------------------
    // Checking
    // ------------------------------------------------------------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // SPI driver tasks (mode 0, MSB first)
    // ------------------------------------------------------------------
    task automatic cs_low();
        ncs_spi = 1'b0;
        #HALF;
    endtask

    task automatic cs_high();
        #HALF;
        ncs_spi = 1'b1;
        #(2*HALF);
    endtask

    // Sends mo[n-1:0] MSB first, returns the MISO bits in mi[n-1:0].
    task automatic xfer(input int n, input logic [63:0] mo, output logic [63:0] mi);
        mi = '0;
        for (int i = n - 1; i >= 0; i--) begin
            mosi_spi = mo[i];
            #HALF;
            mi = {mi[62:0], miso_spi};
            sck_spi = 1'b1;
            #HALF;
            sck_spi = 1'b0;
        end
    endtask

    // ------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------
    localparam logic [127:0] CFG_AFTER_WR = {32'h0, 32'h12345678, 32'hDEADBEEF, 32'h0};

    initial begin
        logic [63:0] r;
        logic [63:0] r2;

        // Reset values
        #100;
        check("rst_cmd_out", cmd_out, 8'h00);
        check("rst_cfg_out", cfg_out, '0);
        check("rst_ctl", {cfg_wr_stb, tbl_we, spi_busy, miso_spi}, '0);
        check("rst_mem_tbl", {mem_addr, tbl_addr, tbl_data}, '0);
        check("rst_state", dbg_state, ST_IDLE);
        rst_n = 1'b1;
        #100;

        // 1: read cfg0 -> ID byte then CFG_RST, no strobes
        cs_low();
        xfer(8, 64'h00, r);
        check("t1_id_byte", r, 64'h91);
        xfer(32, 64'h0, r);
        check("t1_cfg0_rb", r, 64'h0);
        check("t1_busy", spi_busy, 1'b1);
        cs_high();
        check("t1_no_stb", stb_vec(), 32'h0);
        check("t1_cmd_out", cmd_out, 8'h00);

        // 2: burst write cfg1, cfg2
        cs_low();
        xfer(8, 64'h81, r);
        check("t2_id_byte", r, 64'h91);
        xfer(32, 64'hDEADBEEF, r);
        check("t2_rb1", r, 64'h0);
        xfer(32, 64'h12345678, r);
        check("t2_rb2", r, 64'h0);
        cs_high();
        check("t2_cfg_out", cfg_out, CFG_AFTER_WR);
        check("t2_stb", stb_vec(), 32'h00_01_01_00);
        check("t2_cmd_out", cmd_out, 8'h81);

        // 2b: burst readback of cfg1, cfg2 without write
        cs_low();
        xfer(8, 64'h01, r);
        xfer(64, 64'hFFFF_FFFF_FFFF_FFFF, r);
        check("t2b_rb", r, 64'hDEADBEEF_12345678);
        cs_high();
        check("t2b_cfg_out", cfg_out, CFG_AFTER_WR);
        check("t2b_stb", stb_vec(), 32'h00_01_01_00);

        // 3: buffer read with status prefix
        status_in = 16'hA5A5;
        cs_low();
        xfer(8, 64'hA0, r);   // write bit set, must be ignored
        check("t3_id_byte", r, 64'h91);
        xfer(16, 64'h0, r);
        check("t3_status", r, 64'hA5A5);
        xfer(32, 64'h0, r);
        check("t3_words01", r, 64'h0100_0101);
        xfer(15, 64'h0, r);
        check("t3_mem_addr", mem_addr, 11'd3);
        xfer(1, 64'h0, r2);
        check("t3_word2", {r[14:0], r2[0]}, 16'h0102);
        cs_high();
        check("t3_cmd_out", cmd_out, 8'hA0);

        // 4: table 1 writes with address wrap
        cs_low();
        xfer(8, 64'hC1, r);
        check("t4_id_byte", r, 64'h91);
        xfer(16, 64'h01FF, r);
        check("t4_miso_addr", r, 64'h0);
        xfer(16, 64'h1122, r);
        check("t4_miso_data", r, 64'h0);
        cs_high();
        check("t4_log_size", tbl_log.size(), 2);
        if (tbl_log.size() >= 2) begin
            check("t4_wr0", tbl_log[0], {8'h02, 16'h01FF, 8'h11});
            check("t4_wr1", tbl_log[1], {8'h02, 16'h0000, 8'h22});
        end
        check("t4_we_cycles", we_vec(), 16'h0200);
        check("t4_tbl_addr", tbl_addr, 9'h001);
        check("t4_stb", stb_vec(), 32'h00_01_01_00);

        // 5: illegal cfg index, then aborted partial write
        cs_low();
        xfer(8, 64'h9F, r);
        check("t5_id_byte", r, 64'h91);
        xfer(32, 64'hFFFF_FFFF, r);
        check("t5_miso_ign", r, 64'h0);
        check("t5_state_ign", dbg_state, ST_IGNORE);
        cs_high();
        cs_low();
        xfer(8, 64'h80, r);
        xfer(20, 64'hABCDE, r);
        check("t5_rb0_part", r, 64'h0);
        cs_high();
        check("t5_cfg_out", cfg_out, CFG_AFTER_WR);
        check("t5_stb", stb_vec(), 32'h00_01_01_00);
        check("t5_busy", spi_busy, 1'b0);
        check("t5_state", dbg_state, ST_IDLE);

        // Reset mid-session: immediate abort, registers back to CFG_RST
        cs_low();
        xfer(8, 64'h81, r);
        xfer(16, 64'hCAFE, r);
        rst_n = 1'b0;
        #20;
        check("rst2_cfg_out", cfg_out, '0);
        check("rst2_state", {dbg_state, spi_busy, cmd_out}, {ST_IDLE, 1'b0, 8'h00});
        ncs_spi = 1'b1;
        #40;
        rst_n = 1'b1;
        #100;
        check("rst2_stb", stb_vec(), 32'h00_01_01_00);

        // 6: ID query
        cs_low();
        xfer(8, 64'h60, r);
        check("t6_id_byte", r, 64'h91);
        xfer(32, 64'hFFFF_FFFF, r);
        check("t6_id_word", r, 64'h9102_0402);
        xfer(8, 64'h0, r);
        check("t6_after_id", r, 64'h0);
        cs_high();
        check("t6_cmd_out", cmd_out, 8'h60);
        check("t6_cfg_out", cfg_out, '0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
